program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus of the program loader.
// The master side is the loader; the slave side is the byte source plus program memory.
interface program_loader_if #(
    parameter int AW = 5
) ();
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Serial program loader: a count byte N, then N big-endian 32-bit words are written
// to program memory while the CPU is held in reset.
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int AW           = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    program_loader_if.master      bus,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [AW:0]           words_loaded
);
    typedef enum logic [2:0] {IDLE, COUNT, DATA, DONE, ERROR} stateT;

    localparam logic [31:0] depthLimit = 32'(MEMORY_DEPTH);

    stateT       state;
    stateT       nextState;
    logic [1:0]  byteCnt;
    logic [23:0] shiftReg;
    logic [AW:0] wordCount;
    logic        readyInt;
    logic        accept;
    logic        lastWord;

    assign readyInt       = (state == COUNT) || (state == DATA);
    assign accept         = bus.byte_valid && readyInt;
    assign lastWord       = (words_loaded + (AW+1)'(1)) == wordCount;
    assign bus.byte_ready = readyInt;
    assign load_done      = (state == DONE);
    assign load_error     = (state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (start) nextState = COUNT;
            end
            COUNT: begin
                if (accept) begin
                    if (bus.byte_in == 8'd0) begin
                        nextState = DONE;
                    end else if ({24'd0, bus.byte_in} > depthLimit) begin
                        nextState = ERROR;
                    end else begin
                        nextState = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && byteCnt == 2'd3 && lastWord) nextState = DONE;
            end
            DONE, ERROR: begin
                if (start) nextState = COUNT;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byteCnt       <= '0;
            shiftReg      <= '0;
            wordCount     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            words_loaded  <= '0;
            cpu_reset     <= 1'b1;
        end else begin
            bus.mem_we <= 1'b0;
            // Registered so the CPU stays in reset through the final write strobe
            // and is re-held immediately when a new load starts from DONE.
            cpu_reset  <= !(state == DONE && nextState == DONE);

            if (nextState == COUNT && state != COUNT) begin
                words_loaded <= '0;
                byteCnt      <= '0;
            end

            if (accept && state == COUNT) begin
                wordCount <= (AW+1)'(bus.byte_in);
                byteCnt   <= '0;
            end

            if (accept && state == DATA) begin
                byteCnt <= byteCnt + 2'd1;
                if (byteCnt == 2'd3) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= words_loaded[AW-1:0];
                    bus.mem_wdata <= {shiftReg, bus.byte_in};
                    words_loaded  <= words_loaded + (AW+1)'(1);
                end else begin
                    shiftReg <= {shiftReg[15:0], bus.byte_in};
                end
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued by the
// stimulus and popped by a monitor whenever the loader strobes mem_we.
module tb_program_loader;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wrT;

    logic          clk;
    logic          reset;
    logic          start;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    int checks;
    int failures;
    wrT expQ[$];

    program_loader_if #(.AW(AW)) bus ();

    program_loader #(.MEMORY_DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=0x%08h expected no write at %0t",
                         bus.mem_addr, bus.mem_wdata, $time);
            end else begin
                wrT e;
                e = expQ.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", bus.mem_wdata, e.data);
                check("wr_cpu_reset_held", 32'(cpu_reset), 32'd1);
                check("wr_words_loaded", 32'(words_loaded), 32'(e.addr) + 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        start = $urandom_range(0, 1) == 1;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'($urandom);
        @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    // Offers bytes while the loader is not ready; none may be taken.
    task automatic garbage(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.byte_valid = $urandom_range(0, 1) == 1;
            bus.byte_in = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
    endtask

    // Called and returns at a negedge; returns on the negedge after acceptance.
    task automatic sendByte(input logic [7:0] b);
        int gap;
        int t;
        gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) begin
            bus.byte_valid = 1'b0;
            bus.byte_in = 8'($urandom);
            start = $urandom_range(0, 3) == 0;
            @(negedge clk);
        end
        start = 1'b0;
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.byte_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL byte_ready_timeout got=0 expected=1 at %0t", $time);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulseStart(input bit withByte);
        bus.byte_valid = withByte;
        bus.byte_in = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.byte_valid = 1'b0;
        check("start_byte_ready", 32'(bus.byte_ready), 32'd1);
        check("start_cpu_reset", 32'(cpu_reset), 32'd1);
        check("start_load_done", 32'(load_done), 32'd0);
        check("start_load_error", 32'(load_error), 32'd0);
        check("start_words_loaded", 32'(words_loaded), 32'd0);
    endtask

    // Reference: N=0 finishes empty, N>DEPTH errors, otherwise word i lands at address i.
    task automatic loadProgram(input int n, input logic [31:0] words[$], input bit withByte);
        wrT e;
        pulseStart(withByte);
        sendByte(8'(n));
        if (n == 0) begin
            check("n0_load_done", 32'(load_done), 32'd1);
            check("n0_mem_we", 32'(bus.mem_we), 32'd0);
            check("n0_words_loaded", 32'(words_loaded), 32'd0);
            check("n0_byte_ready", 32'(bus.byte_ready), 32'd0);
            @(negedge clk);
            check("n0_cpu_release", 32'(cpu_reset), 32'd0);
        end else if (n > DEPTH) begin
            for (int c = 0; c < 3; c++) begin
                check("err_load_error", 32'(load_error), 32'd1);
                check("err_cpu_reset", 32'(cpu_reset), 32'd1);
                check("err_byte_ready", 32'(bus.byte_ready), 32'd0);
                check("err_load_done", 32'(load_done), 32'd0);
                garbage(1);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                e.addr = AW'(i);
                e.data = words[i];
                expQ.push_back(e);
            end
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    sendByte(8'((words[i] >> (8 * (3 - k))) & 32'hFF));
                end
            end
            check("last_mem_we", 32'(bus.mem_we), 32'd1);
            check("last_load_done", 32'(load_done), 32'd1);
            check("last_cpu_reset_held", 32'(cpu_reset), 32'd1);
            @(negedge clk);
            check("post_cpu_release", 32'(cpu_reset), 32'd0);
            check("post_mem_we", 32'(bus.mem_we), 32'd0);
            check("post_words_loaded", 32'(words_loaded), 32'(n));
            check("post_hold_addr", 32'(bus.mem_addr), 32'(n - 1));
            check("post_hold_data", bus.mem_wdata, words[n - 1]);
            check("post_queue_drained", 32'(expQ.size()), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] w[$];
        int n;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'd0;
        repeat (2) @(negedge clk);
        applyReset();

        garbage(4);
        check("idle_no_accept_words", 32'(words_loaded), 32'd0);
        check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

        w = '{32'h20080005, 32'h01095020};
        loadProgram(2, w, 1'b1);

        garbage(5);
        check("done_hold_words", 32'(words_loaded), 32'd2);
        check("done_hold_load_done", 32'(load_done), 32'd1);

        w = '{};
        loadProgram(0, w, 1'b1);
        loadProgram(DEPTH + 1, w, 1'b0);

        // Partial load cut short by reset must not produce a write.
        pulseStart(1'b0);
        sendByte(8'd1);
        sendByte(8'h11);
        sendByte(8'h22);
        applyReset();
        garbage(6);
        check("abort_queue_empty", 32'(expQ.size()), 32'd0);
        w = '{32'hAABBCCDD};
        loadProgram(1, w, 1'b0);

        w = '{};
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        loadProgram(DEPTH, w, 1'b1);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, DEPTH + 4);
            w = '{};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            garbage($urandom_range(0, 4));
            loadProgram(n, w, $urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
